// File: rtl/posit_encode_seq.sv
// posit_encode_seq
// Sequential posit encoder. Packs an unpacked posit (sign, binary scale,
// fraction, sticky) into an N-bit posit with round-to-nearest-even. The
// regime is inserted one bit per cycle by shifting a 2N-bit work register.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. in_ready is high only in IDLE and out_valid
// only in DONE; both decode registered state, so no input reaches an output
// combinationally. out_posit holds its value until the next result.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  operand handshake
//   in_sign            result sign
//   in_scale           signed scale, value = 2^scale * 1.frac
//   in_frac            fraction bits after the hidden 1, MSB first
//   in_sticky          OR of fraction bits below in_frac
//   in_zero, in_nar    special results (NaR has priority)
//   out_valid/out_ready result handshake
//   out_posit          encoded posit
//   dbg_state_o        current FSM state (0 IDLE, 1 SHIFT, 2 ROUND, 3 DONE)
module posit_encode_seq #(
  parameter int N  = 32,
  parameter int es = 2,
  localparam int Bs = $clog2(N),
  localparam int SW = es + Bs + 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [SW-1:0] in_scale,
  input  logic [N-1:0]  in_frac,
  input  logic          in_sticky,
  input  logic          in_zero,
  input  logic          in_nar,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit,
  output logic [1:0]    dbg_state_o
);

  localparam int KW = SW - es;
  localparam logic signed [KW-1:0] K_MAX = KW'(N - 2);
  localparam logic signed [KW-1:0] K_MIN = KW'(-(N - 1));

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, ROUND = 2'd2, DONE = 2'd3} state_t;

  state_t          state_q;
  logic [2*N-1:0]  w_q;
  logic            sticky_q;
  logic            fill_q;
  logic            sign_q;
  logic [Bs-1:0]   cnt_q;
  logic [N-1:0]    out_q;

  // ---------------------------------------------------------------- decode
  // Dropping the low es bits of the scale is an arithmetic shift (floor).
  logic signed [KW-1:0] k;
  logic [es-1:0]        e;
  logic                 k_neg;
  logic [KW-1:0]        m_full;
  logic [Bs-1:0]        m;
  logic                 special;
  logic [N-1:0]         special_mag;
  logic [N-1:0]         special_res;
  logic [2*N-1:0]       w_load;

  always_comb begin
    k           = signed'(in_scale[SW-1:es]);
    e           = in_scale[es-1:0];
    k_neg       = k[KW-1];
    m_full      = k_neg ? KW'(-k) : KW'(k + KW'(1));
    m           = m_full[Bs-1:0];
    special     = in_nar | in_zero | (k >= K_MAX) | (k <= K_MIN);
    special_mag = '0;
    special_res = '0;
    if (k >= K_MAX) begin
      special_mag = {1'b0, {(N-1){1'b1}}};
    end else begin
      special_mag = {{(N-1){1'b0}}, 1'b1};
    end
    // Sign applies to clamps only; NaR and zero are sign-less encodings.
    if (in_nar) begin
      special_res = {1'b1, {(N-1){1'b0}}};
    end else if (in_zero) begin
      special_res = '0;
    end else if (in_sign) begin
      special_res = -special_mag;
    end else begin
      special_res = special_mag;
    end
    // Terminating regime bit sits at the top; the fill bits shift in above it.
    w_load = {k_neg, e, in_frac, {(N-es-1){1'b0}}};
  end

  // ---------------------------------------------------------------- round
  logic [N-2:0] mag;
  logic         lsb_b;
  logic         guard_b;
  logic         st_b;
  logic         ulp;
  logic [N-1:0] sum;
  logic [N-2:0] mag_r;
  logic [N-1:0] res;

  always_comb begin
    mag     = w_q[2*N-1:N+1];
    lsb_b   = w_q[N+1];
    guard_b = w_q[N];
    st_b    = sticky_q | (|w_q[N-1:0]);
    ulp     = guard_b & (lsb_b | st_b);
    sum     = {1'b0, mag} + {{(N-1){1'b0}}, ulp};
    // A carry out of the magnitude would reach the NaR pattern: saturate.
    mag_r   = sum[N-1] ? {(N-1){1'b1}} : sum[N-2:0];
    res     = sign_q ? -{1'b0, mag_r} : {1'b0, mag_r};
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      w_q      <= '0;
      sticky_q <= 1'b0;
      fill_q   <= 1'b0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q <= in_sign;
            if (special) begin
              out_q   <= special_res;
              state_q <= DONE;
            end else begin
              w_q      <= w_load;
              sticky_q <= in_sticky;
              fill_q   <= ~k_neg;
              cnt_q    <= m;
              state_q  <= (m == '0) ? ROUND : SHIFT;
            end
          end
        end
        SHIFT: begin
          w_q      <= {fill_q, w_q[2*N-1:1]};
          sticky_q <= sticky_q | w_q[0];
          cnt_q    <= cnt_q - Bs'(1);
          if (cnt_q == Bs'(1)) begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          out_q   <= res;
          state_q <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_posit   = out_q;
  assign dbg_state_o = state_q;

endmodule
